// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: boot-time byte-stream loader that fills the mips32 core memory and holds the core until a valid image is in.
//   Optional feature: define LOADER_CSUM_EN to append and verify a 32-bit checksum word after the data words.
//   Ports:
//     clk1_i          clock, rising edge
//     rst_i           asynchronous reset, active-high
//     start_i         one-cycle pulse, begins a load from IDLE/DONE/ERR
//     in_data_i       stream byte
//     in_valid_i      stream byte valid
//     in_ready_o      loader accepts a byte this cycle
//     mem_we_o        memory write strobe, one cycle per word
//     mem_addr_o      memory word address
//     mem_wdata_o     memory write data
//     busy_o          load in progress
//     done_o          image loaded OK (level)
//     error_o         load failed (level)
//     core_hold_o     1 = keep core halted
//     words_loaded_o  count of data words written
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              core_hold_o,
    output logic [ADDR_W:0]   words_loaded_o
);
`ifdef LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;
`endif
    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       part_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   words_loaded_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       word;
    logic              acc, word_done, go, last_wr;
`ifdef LOADER_CSUM_EN
    logic [31:0]       sum_q;
`endif
    // The 4th byte completes the word combinationally so it can be acted on at its accepting edge.
    assign word      = {part_q, in_data_i};
    assign acc       = in_valid_i && in_ready_o;
    assign word_done = acc && byte_cnt_q == 2'd3;
    assign go        = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
    // Leave LOAD only once the final write strobe is on the bus, so mem_we never appears outside LOAD.
    assign last_wr   = mem_we_q && words_loaded_q == n_q - 1'b1;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign words_loaded_o = words_loaded_q;

    always_ff @(posedge clk1_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start_i) state_d = HDR;
            HDR:  if (word_done) state_d = (word == 32'd0 || word > 32'(MAX_WORDS)) ? ERR : LOAD;
`ifdef LOADER_CSUM_EN
            LOAD: if (last_wr) state_d = CSUM;
            CSUM: if (word_done) state_d = (word == sum_q) ? DONE : ERR;
`else
            LOAD: if (last_wr) state_d = DONE;
`endif
            default: state_d = state_q;
        endcase
    end

    always_comb begin
`ifdef LOADER_CSUM_EN
        busy_o = state_q == HDR || state_q == LOAD || state_q == CSUM;
`else
        busy_o = state_q == HDR || state_q == LOAD;
`endif
        in_ready_o  = busy_o;
        done_o      = state_q == DONE;
        error_o     = state_q == ERR;
        core_hold_o = state_q != DONE;
    end

    always_ff @(posedge clk1_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt_q     <= '0;
            part_q         <= '0;
            n_q            <= '0;
            words_loaded_q <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
`ifdef LOADER_CSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            mem_we_q <= state_q == LOAD && word_done;
            if (go) begin
                byte_cnt_q     <= '0;
                words_loaded_q <= '0;
`ifdef LOADER_CSUM_EN
                sum_q          <= '0;
`endif
            end else begin
                if (acc) begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    part_q     <= {part_q[15:0], in_data_i};
                end
                if (mem_we_q) words_loaded_q <= words_loaded_q + 1'b1;
            end
            if (state_q == HDR && word_done) n_q <= word[ADDR_W:0];
            if (state_q == LOAD && word_done) begin
                mem_addr_q  <= ADDR_W'(BASE_ADDR) + words_loaded_q[ADDR_W-1:0];
                mem_wdata_q <= word;
`ifdef LOADER_CSUM_EN
                sum_q       <= sum_q + word;
`endif
            end
        end
    end
endmodule
